// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - ILI9341-class LCD reset/init/frame sequencer driving a 9-bit SPI master
// Purpose: pulses the LCD hardware reset, plays a fixed init table with delays, then for
//   every frame sets the full-screen window and streams WIDTH*HEIGHT RGB565 pixels read
//   from a sync-read frame RAM as {dc,byte} words (dc=0 command, dc=1 data).
// Ports:
//   clk, rst            system clock; synchronous active-low reset
//   frame_start         request one frame refresh, sampled in IDLE only
//   pix_addr, pix_data  frame RAM read address / pixel (valid one cycle after address)
//   spi_idle            SPI master idle
//   spi_data, spi_valid {dc,byte} word and its one-cycle strobe
//   lcd_rst             LCD hardware reset, active low
//   init_done           init table complete, held until rst
//   frame_busy          high from frame accept until the last pixel byte is accepted
// Configuration: define FRAME_LOOP_EN for continuous refresh (each frame chains into the
//   next window sequence; frame_busy drops for one cycle between frames).
module lcd_sequencer #(
  parameter int unsigned WIDTH      = 240,
  parameter int unsigned HEIGHT     = 320,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned RST_CYCLES = 50000,
  parameter int unsigned DELAY_UNIT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [15:0]       pix_data,
  input  logic              spi_idle,
  output logic [8:0]        spi_data,
  output logic              spi_valid,
  output logic              lcd_rst,
  output logic              init_done,
  output logic              frame_busy
);

  typedef enum logic [3:0] {
    RST_LOW, RST_WAIT, INIT_SEND, INIT_DELAY, IDLE, WIN_SEND, PIX_FETCH, PIX_HI, PIX_LO
  } state_t;

  localparam logic [1:0] K_WORD  = 2'd0;
  localparam logic [1:0] K_DELAY = 2'd1;
  localparam logic [1:0] K_END   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [15:0]       X_END     = 16'(WIDTH - 1);
  localparam logic [15:0]       Y_END     = 16'(HEIGHT - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [3:0]  idx;
  logic        hold;       // cycle after a strobe: master has not yet dropped idle
  logic [15:0] pix_latch;
  logic        last_pix;

  logic [12:0] ent;        // init entry {kind, ticks, word}
  logic [1:0]  ent_kind;
  logic [1:0]  ent_ticks;
  logic [8:0]  ent_word;
  logic [31:0] delay_len;
  logic [8:0]  win_word;
  logic        can_send;

  always_comb begin
    case (idx)
      4'd0:    ent = {K_WORD,  2'd0, 9'h001};
      4'd1:    ent = {K_DELAY, 2'd3, 9'h000};
      4'd2:    ent = {K_WORD,  2'd0, 9'h011};
      4'd3:    ent = {K_DELAY, 2'd3, 9'h000};
      4'd4:    ent = {K_WORD,  2'd0, 9'h03A};
      4'd5:    ent = {K_WORD,  2'd0, 9'h155};
      4'd6:    ent = {K_WORD,  2'd0, 9'h036};
      4'd7:    ent = {K_WORD,  2'd0, 9'h148};
      4'd8:    ent = {K_WORD,  2'd0, 9'h029};
      4'd9:    ent = {K_DELAY, 2'd1, 9'h000};
      default: ent = {K_END,   2'd0, 9'h000};
    endcase
  end

  assign ent_kind  = ent[12:11];
  assign ent_ticks = ent[10:9];
  assign ent_word  = ent[8:0];
  assign delay_len = 32'(ent_ticks) * DELAY_UNIT;

  always_comb begin
    case (idx)
      4'd0:    win_word = 9'h02A;
      4'd3:    win_word = {1'b1, X_END[15:8]};
      4'd4:    win_word = {1'b1, X_END[7:0]};
      4'd5:    win_word = 9'h02B;
      4'd8:    win_word = {1'b1, Y_END[15:8]};
      4'd9:    win_word = {1'b1, Y_END[7:0]};
      4'd10:   win_word = 9'h02C;
      default: win_word = 9'h100;
    endcase
  end

  assign can_send = spi_idle && !hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RST_LOW;
      cnt        <= 32'd0;
      idx        <= 4'd0;
      hold       <= 1'b0;
      pix_latch  <= 16'd0;
      last_pix   <= 1'b0;
      pix_addr   <= '0;
      spi_data   <= 9'd0;
      spi_valid  <= 1'b0;
      lcd_rst    <= 1'b0;
      init_done  <= 1'b0;
      frame_busy <= 1'b0;
    end else begin
      // A strobe lasts one cycle and is always followed by one ignored-idle cycle;
      // every send state below advances on the strobe cycle (spi_valid=1).
      hold <= 1'b0;
      if (spi_valid) begin
        spi_valid <= 1'b0;
        hold      <= 1'b1;
      end
      case (state)
        RST_LOW: begin
          if (cnt == RST_CYCLES - 1) begin
            cnt     <= 32'd0;
            lcd_rst <= 1'b1;
            state   <= RST_WAIT;
          end else cnt <= cnt + 32'd1;
        end
        RST_WAIT: begin
          if (cnt == RST_CYCLES - 1) begin
            cnt   <= 32'd0;
            idx   <= 4'd0;
            state <= INIT_SEND;
          end else cnt <= cnt + 32'd1;
        end
        INIT_SEND: begin
          if (spi_valid) idx <= idx + 4'd1;
          else if (ent_kind == K_END) begin
            init_done <= 1'b1;
            idx       <= 4'd0;
            state     <= IDLE;
          end else if (can_send) begin
            // Delays start once the previous command has fully left the SPI master.
            if (ent_kind == K_DELAY) begin
              cnt   <= 32'd0;
              state <= INIT_DELAY;
            end else begin
              spi_valid <= 1'b1;
              spi_data  <= ent_word;
            end
          end
        end
        INIT_DELAY: begin
          if (cnt == delay_len - 32'd1) begin
            cnt   <= 32'd0;
            idx   <= idx + 4'd1;
            state <= INIT_SEND;
          end else cnt <= cnt + 32'd1;
        end
        IDLE: begin
          if (frame_start) begin
            frame_busy <= 1'b1;
            idx        <= 4'd0;
            state      <= WIN_SEND;
          end
        end
        WIN_SEND: begin
          frame_busy <= 1'b1;  // re-raises busy after the one-cycle gap in loop mode
          if (spi_valid) begin
            if (idx == 4'd10) begin
              idx   <= 4'd0;
              cnt   <= 32'd0;
              state <= PIX_FETCH;
            end else idx <= idx + 4'd1;
          end else if (can_send) begin
            spi_valid <= 1'b1;
            spi_data  <= win_word;
          end
        end
        PIX_FETCH: begin
          // First cycle lets the RAM register pix_addr; second captures its output.
          if (cnt != 32'd0) begin
            pix_latch <= pix_data;
            cnt       <= 32'd0;
            state     <= PIX_HI;
          end else cnt <= 32'd1;
        end
        PIX_HI: begin
          if (spi_valid) begin
            // Advance the address now so the next RAM read overlaps the low-byte wait.
            last_pix <= (pix_addr == LAST_ADDR);
            if (pix_addr != LAST_ADDR) pix_addr <= pix_addr + ADDR_W'(1);
            state <= PIX_LO;
          end else if (can_send) begin
            spi_valid <= 1'b1;
            spi_data  <= {1'b1, pix_latch[15:8]};
          end
        end
        PIX_LO: begin
          if (spi_valid) begin
            if (last_pix) begin
              last_pix   <= 1'b0;
              pix_addr   <= '0;
              frame_busy <= 1'b0;
              idx        <= 4'd0;
`ifdef FRAME_LOOP_EN
              state      <= WIN_SEND;
`else
              state      <= IDLE;
`endif
            end else begin
              cnt   <= 32'd0;
              state <= PIX_FETCH;
            end
          end else if (can_send) begin
            spi_valid <= 1'b1;
            spi_data  <= {1'b1, pix_latch[7:0]};
          end
        end
        default: state <= RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer with an SPI master and frame RAM model
module tb_lcd_sequencer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 3;
  localparam int RC   = 8;
  localparam int DU   = 4;
  localparam int BUSY = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] pix_addr;
  logic [15:0]   pix_data;
  logic          spi_idle;
  logic [8:0]    spi_data;
  logic          spi_valid;
  logic          lcd_rst;
  logic          init_done;
  logic          frame_busy;

  logic          force_busy = 1'b0;
  logic [15:0]   ram [W*H];
  logic [8:0]    obs_q [$];
  int            t_q [$];
  int            cyc = 0;
  int            busy = 0;
  logic          prev_valid = 1'b0;
  logic          idle_at_edge = 1'b1;
  int            b2b_cnt = 0;
  int            noidle_cnt = 0;
  int            compared = 0;
  int            mismatched = 0;

  lcd_sequencer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RST_CYCLES(RC), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .spi_idle(spi_idle), .spi_data(spi_data), .spi_valid(spi_valid),
    .lcd_rst(lcd_rst), .init_done(init_done), .frame_busy(frame_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    idle_at_edge <= spi_idle;
    pix_data     <= ram[pix_addr];
  end

  // SPI master: idle drops for BUSY cycles after each strobe; every strobe is recorded.
  always @(negedge clk) begin
    if (spi_valid === 1'b1) begin
      obs_q.push_back(spi_data);
      t_q.push_back(cyc);
      if (prev_valid) b2b_cnt <= b2b_cnt + 1;
      if (!idle_at_edge) noidle_cnt <= noidle_cnt + 1;
      busy <= BUSY;
    end else if (busy > 0) busy <= busy - 1;
    prev_valid <= (spi_valid === 1'b1);
  end

  assign spi_idle = (busy == 0) && !force_busy;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin step(); k++; end
    check("wait_words", 32'(obs_q.size() >= n), 1);
  endtask

  task automatic wait_frame_end();
    int k = 0;
    while (frame_busy !== 1'b0 && k < 3000) begin step(); k++; end
    check("frame_busy_fall", frame_busy, 0);
  endtask

  task automatic check_init();
    int exp_q [$];
    int k;
    exp_q = {'h001, 'h011, 'h03A, 'h155, 'h036, 'h148, 'h029};
    wait_words(7, 3000);
    check("init_not_done_yet", init_done, 0);
    check("init_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("init_w%0d", i), obs_q[i], exp_q[i]);
    if (t_q.size() >= 7) begin
      check("init_gap_01_11", 32'(t_q[1] - t_q[0] >= 3*DU + BUSY), 1);
      k = 0;
      while (init_done !== 1'b1 && k < 500) begin step(); k++; end
      check("init_done_rise", init_done, 1);
      check("init_done_after_delay", 32'(cyc - t_q[6] >= DU + BUSY), 1);
    end
  endtask

  // Reference: window command set for a full screen, then each pixel high byte then low byte.
  task automatic check_frame();
    int exp_q [$];
    exp_q = {'h02A, 'h100, 'h100, 'h100 + ((W-1) >> 8), 'h100 + ((W-1) % 256),
             'h02B, 'h100, 'h100, 'h100 + ((H-1) >> 8), 'h100 + ((H-1) % 256), 'h02C};
    for (int i = 0; i < W*H; i++) begin
      exp_q.push_back('h100 + int'(ram[i]) / 256);
      exp_q.push_back('h100 + int'(ram[i]) % 256);
    end
    check("frame_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("frame_w%0d", i), obs_q[i], exp_q[i]);
    check("pix_addr_wrap", pix_addr, 0);
  endtask

  task automatic next_frame();
    obs_q.delete();
    t_q.delete();
    for (int i = 0; i < W*H; i++) ram[i] = 16'($urandom);
`ifdef FRAME_LOOP_EN
    step();
    check("loop_busy_gap_one_cycle", frame_busy, 1);
`else
    repeat (30) step();
    check("idle_no_strobe", obs_q.size(), 0);
    frame_start = 1'b1;
    step();
    check("accept_busy", frame_busy, 1);
    frame_start = 1'b0;
    step();
    check("first_latency", obs_q.size(), 1);
`endif
  endtask

  initial begin
    int n;
    int n0;
    for (int i = 0; i < W*H; i++) ram[i] = 16'hA500 + 16'(i);

    repeat (3) step();
    check("rst_lcd_rst", lcd_rst, 0);
    check("rst_spi_valid", spi_valid, 0);
    check("rst_spi_data", spi_data, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_init_done", init_done, 0);
    check("rst_frame_busy", frame_busy, 0);

    rst = 1'b1;
    n = 0;
    while (lcd_rst !== 1'b1 && n < 100) begin step(); n++; end
    check("lcd_rst_low_cycles", n, RC);
    check("no_strobe_before_init", obs_q.size(), 0);
    n = 0;
    while (obs_q.size() == 0 && n < 200) begin step(); n++; end
    check("first_strobe_delay", n, RC + 1);
    check_init();

    // Frame 1: RAM[i] = A500+i
    obs_q.delete();
    t_q.delete();
    check("idle_busy_low", frame_busy, 0);
    frame_start = 1'b1;
    step();
    check("accept_busy", frame_busy, 1);
    frame_start = 1'b0;
    step();
    check("first_latency", obs_q.size(), 1);
    wait_frame_end();
    check_frame();

    // Frame 2: random pixels, stall the master at a random point, stray frame_start mid-frame
    next_frame();
    wait_words(11 + int'($urandom_range(0, 12)), 3000);
    force_busy  = 1'b1;
    frame_start = 1'b1;
    n0 = obs_q.size();
    step();
    frame_start = 1'b0;
    repeat (39) step();
    check("stall_no_strobe", obs_q.size(), n0);
    force_busy = 1'b0;
    wait_frame_end();
    check_frame();

    // Frame 3: abort with reset during pixel 3, then a full init replay
    next_frame();
    wait_words(16, 3000);
    rst = 1'b0;
    step();
    check("abort_spi_valid", spi_valid, 0);
    check("abort_lcd_rst", lcd_rst, 0);
    check("abort_init_done", init_done, 0);
    check("abort_frame_busy", frame_busy, 0);
    check("abort_pix_addr", pix_addr, 0);
    n0 = obs_q.size();
    repeat (2) step();
    check("abort_no_strobe", obs_q.size(), n0);
    rst = 1'b1;
    obs_q.delete();
    t_q.delete();
    check_init();

    check("no_back_to_back", b2b_cnt, 0);
    check("strobe_only_when_idle", noidle_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
